mdio_frame_engine: RTL

MDIO_FRAME_ENGINE -- requirements
Module: mdio_frame_engine

---
 rtl/mdio_pkg.sv | 41 ++++
 rtl/mdio_sync_edge.sv | 39 +++
 rtl/mdio_frame_engine.sv | 310 +++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/mdio_pkg.sv
// Shared definitions for the MDIO frame engine: field encodings, field
// lengths and the frame-walker state enum.
package mdio_pkg;

   typedef enum logic [2:0] {
      IDLE,
      ST,
      OP,
      PAD,
      RAD,
      TA,
      DATA,
      SKIP
   } mdio_state_e;

   localparam logic [1:0] ST_C22       = 2'b01;
   localparam logic [1:0] ST_C45       = 2'b00;

   localparam logic [1:0] OP_C22_READ  = 2'b10;
   localparam logic [1:0] OP_C22_WRITE = 2'b01;
   localparam logic [1:0] OP_C45_ADDR  = 2'b00;
   localparam logic [1:0] OP_C45_WRITE = 2'b01;
   localparam logic [1:0] OP_C45_READ  = 2'b11;
   localparam logic [1:0] OP_C45_RDINC = 2'b10;

   localparam logic [1:0] TA_WRITE     = 2'b10;

   localparam int ST_LEN    = 2;
   localparam int OP_LEN    = 2;
   localparam int PAD_LEN   = 5;
   localparam int RAD_LEN   = 5;
   localparam int TA_LEN    = 2;
   localparam int DATA_LEN  = 16;
   localparam int FRAME_LEN = ST_LEN + OP_LEN + PAD_LEN + RAD_LEN + TA_LEN + DATA_LEN;

   // Clause 45 reads are 11 and 10 (both have op[1] set); clause 22 read is 10.
   function automatic logic isReadOp(input logic c45, input logic [1:0] op);
      return c45 ? op[1] : (op == OP_C22_READ);
   endfunction

endpackage

// File: rtl/mdio_sync_edge.sv
// Brings mdc and mdio into the clk domain through equal-depth flop chains
// and flags one bit per synchronised mdc rising edge.
module mdio_sync_edge #(
   parameter int STAGES = 2
) (
   input  logic clk,
   input  logic rstn,
   input  logic soft_reset,
   input  logic mdc,
   input  logic mdio_in,
   output logic bit_valid,
   output logic bit_data
);

   logic [STAGES-1:0] mdcSync_q;
   logic [STAGES-1:0] mdioSync_q;
   logic              mdcPrev_q;

   // Shift both lines through identical chains so the data bit lines up with its clock edge.
   always_ff @(posedge clk or negedge rstn) begin
      if (!rstn) begin
         mdcSync_q  <= '0;
         mdioSync_q <= '0;
         mdcPrev_q  <= 1'b0;
      end else if (soft_reset) begin
         mdcSync_q  <= '0;
         mdioSync_q <= '0;
         mdcPrev_q  <= 1'b0;
      end else begin
         mdcSync_q  <= {mdcSync_q[STAGES-2:0], mdc};
         mdioSync_q <= {mdioSync_q[STAGES-2:0], mdio_in};
         mdcPrev_q  <= mdcSync_q[STAGES-1];
      end
   end

   assign bit_valid = mdcSync_q[STAGES-1] & ~mdcPrev_q;
   assign bit_data  = mdioSync_q[STAGES-1];

endmodule

// File: rtl/mdio_frame_engine.sv
// MDIO slave frame engine: decodes clause-22/45 frames from a synchronised
// bus, raises register-access strobes and drives read data back on the bus.
module mdio_frame_engine
   import mdio_pkg::*;
#(
   parameter int PORT_CNT    = 1,
   parameter int PRE_MIN     = 32,
   parameter int SYNC_STAGES = 2,
   parameter int C45_EN      = 1
) (
   input  logic        clk,
   input  logic        rstn,
   input  logic        soft_reset,
   input  logic        mdc,
   input  logic        mdio_in,
   output logic        mdio_out,
   output logic        mdio_oe,
   input  logic [4:0]  phy_base,
   output logic        reg_req,
   output logic        reg_we,
   output logic        reg_c45,
   output logic [2:0]  reg_port,
   output logic [4:0]  reg_devad,
   output logic [15:0] reg_addr,
   output logic [15:0] reg_wdata,
   input  logic [15:0] reg_rdata,
   output logic        frame_err
);

   localparam logic [5:0] PRE_MAX    = 6'(PRE_MIN);
   localparam logic [4:0] OP_LAST    = 5'(OP_LEN - 1);
   localparam logic [4:0] PAD_LAST   = 5'(PAD_LEN - 1);
   localparam logic [4:0] RAD_LAST   = 5'(RAD_LEN - 1);
   localparam logic [4:0] TA_LAST    = 5'(TA_LEN - 1);
   localparam logic [4:0] DATA_LAST  = 5'(DATA_LEN - 1);
   localparam logic [5:0] FRAME_LAST = 6'(FRAME_LEN - 1);

   logic bitValid, bitData;

   mdio_state_e state_q, state_d;
   logic [5:0]  preCnt_q, preCnt_d;
   logic [4:0]  bitCnt_q, bitCnt_d;
   logic [5:0]  frmCnt_q, frmCnt_d;
   logic        c45_q, c45_d;
   logic [1:0]  op_q, op_d;
   logic [3:0]  phy_q, phy_d;
   logic [4:0]  rad_q, rad_d;
   logic [2:0]  port_q, port_d;
   logic        ta_q, ta_d;
   logic [14:0] shift_q, shift_d;
   logic [15:0] addr_q [8];
   logic        addrWe;
   logic [15:0] addrWdata;

   logic        mdioOut_q, mdioOut_d, mdioOe_q, mdioOe_d;
   logic        regReq_q, regReq_d, regWe_q, regWe_d, regC45_q, regC45_d;
   logic [2:0]  regPort_q, regPort_d;
   logic [4:0]  regDevad_q, regDevad_d;
   logic [15:0] regAddr_q, regAddr_d, regWdata_q, regWdata_d;
   logic        frameErr_q, frameErr_d;

   logic [1:0]  opFull;
   logic [4:0]  phyFull, radFull;
   logic [15:0] dataFull, addrCur;
   logic [5:0]  phyExt, baseExt;
   logic        phyMatch, isRd, isAddr;

   mdio_sync_edge #(.STAGES(SYNC_STAGES)) u_sync (
      .clk       (clk),
      .rstn      (rstn),
      .soft_reset(soft_reset),
      .mdc       (mdc),
      .mdio_in   (mdio_in),
      .bit_valid (bitValid),
      .bit_data  (bitData)
   );

   assign opFull   = {op_q[0], bitData};
   assign phyFull  = {phy_q, bitData};
   assign radFull  = {rad_q[3:0], bitData};
   assign dataFull = {shift_q, bitData};
   assign addrCur  = addr_q[port_q];
   assign phyExt   = {1'b0, phyFull};
   assign baseExt  = {1'b0, phy_base};
   assign phyMatch = (phyExt >= baseExt) && (phyExt < baseExt + 6'(PORT_CNT));
   assign isRd     = isReadOp(c45_q, op_q);
   assign isAddr   = c45_q && (op_q == OP_C45_ADDR);

   // Walk the frame one detected bit at a time, deciding strobes and bus drive.
   always_comb begin
      state_d    = state_q;
      preCnt_d   = preCnt_q;
      bitCnt_d   = bitCnt_q;
      frmCnt_d   = frmCnt_q;
      c45_d      = c45_q;
      op_d       = op_q;
      phy_d      = phy_q;
      rad_d      = rad_q;
      port_d     = port_q;
      ta_d       = ta_q;
      shift_d    = shift_q;
      addrWe     = 1'b0;
      addrWdata  = addrCur;
      mdioOut_d  = mdioOut_q;
      mdioOe_d   = mdioOe_q;
      regReq_d   = 1'b0;
      regWe_d    = regWe_q;
      regC45_d   = regC45_q;
      regPort_d  = regPort_q;
      regDevad_d = regDevad_q;
      regAddr_d  = regAddr_q;
      regWdata_d = regWdata_q;
      frameErr_d = 1'b0;
      if (bitValid) begin
         frmCnt_d = frmCnt_q + 6'd1;
         bitCnt_d = bitCnt_q + 5'd1;
         unique case (state_q)
            IDLE: begin
               bitCnt_d = '0;
               frmCnt_d = '0;
               if (bitData) begin
                  preCnt_d = (preCnt_q == PRE_MAX) ? preCnt_q : preCnt_q + 6'd1;
               end else if (preCnt_q == PRE_MAX) begin
                  state_d  = ST;
                  preCnt_d = '0;
                  frmCnt_d = 6'd1;
               end else begin
                  preCnt_d = '0;
               end
            end
            ST: begin
               bitCnt_d = '0;
               if (bitData == ST_C22[0]) begin
                  c45_d   = 1'b0;
                  state_d = OP;
               end else if (C45_EN != 0) begin
                  c45_d   = 1'b1;
                  state_d = OP;
               end else begin
                  frameErr_d = 1'b1;
                  state_d    = SKIP;
               end
            end
            OP: begin
               op_d = opFull;
               if (bitCnt_q == OP_LAST) begin
                  bitCnt_d = '0;
                  if (!c45_q && (opFull != OP_C22_READ) && (opFull != OP_C22_WRITE)) begin
                     frameErr_d = 1'b1;
                     state_d    = SKIP;
                  end else begin
                     state_d = PAD;
                  end
               end
            end
            PAD: begin
               phy_d = phyFull[3:0];
               if (bitCnt_q == PAD_LAST) begin
                  bitCnt_d = '0;
                  if (phyMatch) begin
                     port_d  = 3'(phyFull - phy_base);
                     state_d = RAD;
                  end else begin
                     state_d = SKIP;
                  end
               end
            end
            RAD: begin
               rad_d = radFull;
               if (bitCnt_q == RAD_LAST) begin
                  bitCnt_d = '0;
                  state_d  = TA;
                  if (isRd) begin
                     regReq_d   = 1'b1;
                     regWe_d    = 1'b0;
                     regC45_d   = c45_q;
                     regPort_d  = port_q;
                     regDevad_d = radFull;
                     regAddr_d  = c45_q ? addrCur : 16'h0000;
                  end
               end
            end
            TA: begin
               if (bitCnt_q != TA_LAST) begin
                  ta_d = bitData;
                  if (isRd) begin
                     mdioOe_d  = 1'b1;
                     mdioOut_d = 1'b0;
                  end
               end else begin
                  bitCnt_d = '0;
                  if (isRd) begin
                     shift_d   = reg_rdata[14:0];
                     mdioOut_d = reg_rdata[15];
                     state_d   = DATA;
                     if (c45_q && (op_q == OP_C45_RDINC)) begin
                        addrWe    = 1'b1;
                        addrWdata = addrCur + 16'd1;
                     end
                  end else if ({ta_q, bitData} != TA_WRITE) begin
                     frameErr_d = 1'b1;
                     state_d    = SKIP;
                  end else begin
                     state_d = DATA;
                  end
               end
            end
            DATA: begin
               if (isRd) begin
                  mdioOut_d = shift_q[14];
                  shift_d   = {shift_q[13:0], 1'b0};
               end else begin
                  shift_d = dataFull[14:0];
               end
               if (bitCnt_q == DATA_LAST) begin
                  state_d  = IDLE;
                  preCnt_d = '0;
                  bitCnt_d = '0;
                  if (isRd) begin
                     mdioOe_d  = 1'b0;
                     mdioOut_d = 1'b0;
                  end else if (isAddr) begin
                     addrWe    = 1'b1;
                     addrWdata = dataFull;
                  end else begin
                     regReq_d   = 1'b1;
                     regWe_d    = 1'b1;
                     regC45_d   = c45_q;
                     regPort_d  = port_q;
                     regDevad_d = rad_q;
                     regAddr_d  = c45_q ? addrCur : 16'h0000;
                     regWdata_d = dataFull;
                  end
               end
            end
            SKIP: begin
               if (frmCnt_q == FRAME_LAST) begin
                  state_d  = IDLE;
                  preCnt_d = '0;
                  bitCnt_d = '0;
               end
            end
            default: state_d = IDLE;
         endcase
      end
   end

   // State, datapath and registered outputs; soft_reset clears exactly what rstn clears.
   always_ff @(posedge clk or negedge rstn) begin
      if (!rstn || soft_reset) begin
         state_q    <= IDLE;
         preCnt_q   <= '0;
         bitCnt_q   <= '0;
         frmCnt_q   <= '0;
         c45_q      <= 1'b0;
         op_q       <= '0;
         phy_q      <= '0;
         rad_q      <= '0;
         port_q     <= '0;
         ta_q       <= 1'b0;
         shift_q    <= '0;
         for (int i = 0; i < 8; i++) addr_q[i] <= '0;
         mdioOut_q  <= 1'b0;
         mdioOe_q   <= 1'b0;
         regReq_q   <= 1'b0;
         regWe_q    <= 1'b0;
         regC45_q   <= 1'b0;
         regPort_q  <= '0;
         regDevad_q <= '0;
         regAddr_q  <= '0;
         regWdata_q <= '0;
         frameErr_q <= 1'b0;
      end else begin
         state_q    <= state_d;
         preCnt_q   <= preCnt_d;
         bitCnt_q   <= bitCnt_d;
         frmCnt_q   <= frmCnt_d;
         c45_q      <= c45_d;
         op_q       <= op_d;
         phy_q      <= phy_d;
         rad_q      <= rad_d;
         port_q     <= port_d;
         ta_q       <= ta_d;
         shift_q    <= shift_d;
         if (addrWe) addr_q[port_q] <= addrWdata;
         mdioOut_q  <= mdioOut_d;
         mdioOe_q   <= mdioOe_d;
         regReq_q   <= regReq_d;
         regWe_q    <= regWe_d;
         regC45_q   <= regC45_d;
         regPort_q  <= regPort_d;
         regDevad_q <= regDevad_d;
         regAddr_q  <= regAddr_d;
         regWdata_q <= regWdata_d;
         frameErr_q <= frameErr_d;
      end
   end

   assign mdio_out  = mdioOut_q;
   assign mdio_oe   = mdioOe_q;
   assign reg_req   = regReq_q;
   assign reg_we    = regWe_q;
   assign reg_c45   = regC45_q;
   assign reg_port  = regPort_q;
   assign reg_devad = regDevad_q;
   assign reg_addr  = regAddr_q;
   assign reg_wdata = regWdata_q;
   assign frame_err = frameErr_q;

endmodule
